// File: rtl/bus_arbiter_if.sv
// BusItf: valid/ready request bus with 32-bit address and write data toward the slave
// and 32-bit read data back, one transfer per ready pulse.
interface BusItf;
    logic        valid;
    logic        ready;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] dataM2S;
    logic [31:0] dataS2M;

    modport Master (output valid, output wr, output addr, output dataM2S,
                    input  ready, input  dataS2M);
    modport Slave  (input  valid, input  wr, input  addr, input  dataM2S,
                    output ready, output dataS2M);
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter between the data-cache (master 0) and instruction-cache (master 1) buses
// onto one memory bus. Optional grant timeout with err pulse: define ARB_TIMEOUT_EN.
module bus_arbiter #(
    parameter int unsigned P_TIMEOUT = 64
) (
    input  logic  clk,
    input  logic  rst,
    BusItf.Slave  bDataIf,
    BusItf.Slave  bInsIf,
    BusItf.Master bMemIf,
    output logic  err
);
    localparam int unsigned P_W_TCNT = $clog2(P_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RESP} state_e;

    state_e state_q, state_d;
    logic   gnt_q, gnt_d;
    logic   prio_q, prio_d;
    logic   winner;
    logic   timeout;
    logic   grant_ready;
    logic [31:0] resp_data;

`ifdef ARB_TIMEOUT_EN
    logic [P_W_TCNT-1:0] tcnt_q, tcnt_d;
    logic                abort_q, abort_d;

    // tcnt_q counts completed grant cycles, so the abort lands on grant cycle P_TIMEOUT.
    always_comb begin
        timeout = (state_q == S_GRANT) && !bMemIf.ready
                  && (tcnt_q == P_W_TCNT'(P_TIMEOUT - 1));
    end
`else
    logic unused_cfg;

    always_comb begin
        timeout    = 1'b0;
        unused_cfg = (P_TIMEOUT > 0) && (P_W_TCNT > 0);
    end
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        prio_d  = prio_q;
        winner  = (bDataIf.valid && bInsIf.valid) ? prio_q : bInsIf.valid;
`ifdef ARB_TIMEOUT_EN
        tcnt_d  = tcnt_q;
        abort_d = 1'b0;
`endif
        case (state_q)
            S_IDLE, S_RESP: begin
                if (bDataIf.valid || bInsIf.valid) begin
                    gnt_d   = winner;
                    prio_d  = ~winner;
                    state_d = S_GRANT;
`ifdef ARB_TIMEOUT_EN
                    tcnt_d  = '0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                if (bMemIf.ready || timeout) begin
                    state_d = S_RESP;
`ifdef ARB_TIMEOUT_EN
                    abort_d = timeout;
`endif
                end
`ifdef ARB_TIMEOUT_EN
                else begin
                    tcnt_d = tcnt_q + P_W_TCNT'(1);
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        grant_ready = (state_q == S_GRANT) && (bMemIf.ready || timeout);
        resp_data   = '0;
        if (state_q == S_RESP) begin
`ifdef ARB_TIMEOUT_EN
            resp_data = abort_q ? 32'hDEAD_BEEF : bMemIf.dataS2M;
`else
            resp_data = bMemIf.dataS2M;
`endif
        end

        bMemIf.valid   = (state_q == S_GRANT) && !timeout;
        bMemIf.wr      = 1'b0;
        bMemIf.addr    = '0;
        bMemIf.dataM2S = '0;
        if (state_q == S_GRANT) begin
            bMemIf.wr      = gnt_q ? bInsIf.wr      : bDataIf.wr;
            bMemIf.addr    = gnt_q ? bInsIf.addr    : bDataIf.addr;
            bMemIf.dataM2S = gnt_q ? bInsIf.dataM2S : bDataIf.dataM2S;
        end

        bDataIf.ready   = grant_ready && !gnt_q;
        bInsIf.ready    = grant_ready &&  gnt_q;
        bDataIf.dataS2M = gnt_q ? '0 : resp_data;
        bInsIf.dataS2M  = gnt_q ? resp_data : '0;
        err             = timeout;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= 1'b0;
            prio_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tcnt_q  <= '0;
            abort_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            prio_q  <= prio_d;
`ifdef ARB_TIMEOUT_EN
            tcnt_q  <= tcnt_d;
            abort_q <= abort_d;
`endif
        end
    end

    // A granted master must keep valid up until its ready; the grant is held regardless.
    a_valid_held: assert property (@(posedge clk) disable iff (rst)
        (state_q == S_GRANT) |-> (gnt_q ? bInsIf.valid : bDataIf.valid));

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, single read, contention, write pass-through,
// reset mid-grant, and (with ARB_TIMEOUT_EN) the grant timeout.
module tb_bus_arbiter;
    logic clk;
    logic rst;
    logic err;
    int   n_assert;
    int   n_fail;

    BusItf data_if ();
    BusItf ins_if ();
    BusItf mem_if ();

    bus_arbiter #(.P_TIMEOUT(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .bDataIf (data_if),
        .bInsIf  (ins_if),
        .bMemIf  (mem_if),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        data_if.valid = 1'b1; data_if.wr = 1'b0; data_if.addr = 32'h0000_0100; data_if.dataM2S = '0;
        ins_if.valid  = 1'b1; ins_if.wr  = 1'b0; ins_if.addr  = 32'h0000_0200; ins_if.dataM2S  = '0;
        mem_if.ready  = 1'b1; mem_if.dataS2M = 32'h7777_7777;

        // Reset with both masters requesting and the slave ready
        cyc(); cyc(); #1;
        chk("rst_data_ready", data_if.ready, 1'b0);
        chk("rst_ins_ready", ins_if.ready, 1'b0);
        chk("rst_mem_valid", mem_if.valid, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_data_s2m", data_if.dataS2M, 32'h0);
        chk("rst_ins_s2m", ins_if.dataS2M, 32'h0);
        rst = 1'b0; mem_if.ready = 1'b0; #1;
        chk("rel_idle_valid", mem_if.valid, 1'b0);
        cyc(); #1;
        chk("rel_grant_valid", mem_if.valid, 1'b1);
        chk("rel_grant_addr_data", mem_if.addr, 32'h0000_0100);
        chk("rel_data_ready_wait", data_if.ready, 1'b0);
        mem_if.ready = 1'b1; #1;
        chk("rel_data_ready", data_if.ready, 1'b1);
        chk("rel_ins_ready", ins_if.ready, 1'b0);
        cyc();
        data_if.valid = 1'b0; ins_if.valid = 1'b0;
        mem_if.ready = 1'b0; mem_if.dataS2M = 32'hCAFE_0001; #1;
        chk("rel_resp_data", data_if.dataS2M, 32'hCAFE_0001);
        chk("rel_resp_ins_iso", ins_if.dataS2M, 32'h0);
        chk("rel_resp_valid", mem_if.valid, 1'b0);
        cyc(); #1;
        chk("rel_idle_data_s2m", data_if.dataS2M, 32'h0);

        // Single read from the instruction master, slave ready on grant cycle 3
        ins_if.valid = 1'b1; ins_if.addr = 32'h0000_1000; ins_if.wr = 1'b0; #1;
        chk("rd_req_cycle_valid", mem_if.valid, 1'b0);
        cyc(); #1;
        chk("rd_g1_valid", mem_if.valid, 1'b1);
        chk("rd_g1_addr", mem_if.addr, 32'h0000_1000);
        chk("rd_g1_wr", mem_if.wr, 1'b0);
        chk("rd_g1_ready", ins_if.ready, 1'b0);
        cyc(); #1;
        chk("rd_g2_ready", ins_if.ready, 1'b0);
        cyc(); mem_if.ready = 1'b1; #1;
        chk("rd_g3_ins_ready", ins_if.ready, 1'b1);
        chk("rd_g3_data_ready", data_if.ready, 1'b0);
        cyc();
        mem_if.ready = 1'b0; ins_if.valid = 1'b0; mem_if.dataS2M = 32'h1234_5678; #1;
        chk("rd_resp_ins_data", ins_if.dataS2M, 32'h1234_5678);
        chk("rd_resp_data_iso", data_if.dataS2M, 32'h0);
        chk("rd_resp_valid", mem_if.valid, 1'b0);
        chk("rd_resp_addr", mem_if.addr, 32'h0);
        cyc(); #1;
        chk("rd_idle_ins_s2m", ins_if.dataS2M, 32'h0);

        // Contention: both requesting, slave always ready -> data, ins, data, ins
        data_if.valid = 1'b1; data_if.addr = 32'h0000_0100;
        ins_if.valid  = 1'b1; ins_if.addr  = 32'h0000_0200;
        mem_if.ready  = 1'b1;
        cyc();
        for (int g = 0; g < 4; g++) begin
            #1;
            chk("rr_addr", mem_if.addr, (g % 2 == 1) ? 32'h0000_0200 : 32'h0000_0100);
            chk("rr_data_ready", data_if.ready, (g % 2 == 0) ? 1'b1 : 1'b0);
            chk("rr_ins_ready", ins_if.ready, (g % 2 == 1) ? 1'b1 : 1'b0);
            cyc();
            if (g == 3) begin
                data_if.valid = 1'b0; ins_if.valid = 1'b0;
            end
            #1;
            chk("rr_resp_valid", mem_if.valid, 1'b0);
            cyc();
        end

        // Write pass-through from the data master
        mem_if.ready = 1'b0;
        data_if.valid = 1'b1; data_if.wr = 1'b1; data_if.addr = 32'h0000_2004;
        data_if.dataM2S = 32'hA5A5_A5A5; ins_if.dataM2S = 32'h5A5A_5A5A; #1;
        chk("wr_idle_wr", mem_if.wr, 1'b0);
        chk("wr_idle_dm2s", mem_if.dataM2S, 32'h0);
        cyc(); #1;
        chk("wr_g_wr", mem_if.wr, 1'b1);
        chk("wr_g_addr", mem_if.addr, 32'h0000_2004);
        chk("wr_g_dm2s", mem_if.dataM2S, 32'hA5A5_A5A5);
        cyc(); #1;
        chk("wr_g2_dm2s", mem_if.dataM2S, 32'hA5A5_A5A5);
        mem_if.ready = 1'b1; #1;
        chk("wr_ready", data_if.ready, 1'b1);
        cyc();
        data_if.valid = 1'b0; data_if.wr = 1'b0; mem_if.ready = 1'b0; #1;
        chk("wr_resp_wr", mem_if.wr, 1'b0);
        chk("wr_resp_dm2s", mem_if.dataM2S, 32'h0);
        cyc();

        // Reset mid-grant: prio is 1 here, so a data win afterwards shows prio was cleared
        data_if.valid = 1'b1; data_if.addr = 32'h0000_4000;
        cyc(); #1;
        chk("mr_grant_valid", mem_if.valid, 1'b1);
        rst = 1'b1; mem_if.ready = 1'b1; #1;
        chk("mr_async_valid", mem_if.valid, 1'b0);
        chk("mr_async_ready", data_if.ready, 1'b0);
        chk("mr_async_addr", mem_if.addr, 32'h0);
        cyc(); #1;
        chk("mr_held_valid", mem_if.valid, 1'b0);
        rst = 1'b0; ins_if.valid = 1'b1; ins_if.addr = 32'h0000_5000; #1;
        chk("mr_idle_valid", mem_if.valid, 1'b0);
        cyc(); #1;
        chk("mr_prio_addr", mem_if.addr, 32'h0000_4000);
        chk("mr_prio_data_ready", data_if.ready, 1'b1);
        chk("mr_prio_ins_ready", ins_if.ready, 1'b0);
        cyc();
        data_if.valid = 1'b0; ins_if.valid = 1'b0; mem_if.ready = 1'b0;
        cyc();

`ifdef ARB_TIMEOUT_EN
        // Slave never ready: abort on grant cycle 8
        ins_if.valid = 1'b1; ins_if.addr = 32'h0000_6000;
        cyc();
        for (int k = 1; k < 8; k++) begin
            #1;
            chk("to_wait_err", err, 1'b0);
            chk("to_wait_ready", ins_if.ready, 1'b0);
            cyc();
        end
        #1;
        chk("to_err", err, 1'b1);
        chk("to_ready", ins_if.ready, 1'b1);
        chk("to_valid_drop", mem_if.valid, 1'b0);
        cyc();
        ins_if.valid = 1'b0; #1;
        chk("to_resp_data", ins_if.dataS2M, 32'hDEAD_BEEF);
        chk("to_resp_err", err, 1'b0);
        cyc();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
